uart_tx_frame: RTL and testbench
================================

Name: uart_tx_frame

Overview:
- Transmit-side counterpart to the UART RX path: serialises one parallel byte into a UART frame.
- Frame format: start bit, LSB-first data, optional parity, one stop bit.
- Runs on the same oversampled clock as the receiver. Each bit is held for `prescale` clocks, so TX and RX share one prescale setting.
- Sits between the host/register side (handshake) and the serial pin.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame.
- PRESCALE_WIDTH, 6, width of the prescale input and of the per-bit edge counter.

Ports:
- clk  input  1  oversampled clock (prescale x baud).
- reset  input  1  synchronous, active-high reset.
- p_data  input  DATA_WIDTH  parallel byte to send.
- data_valid  input  1  request; a frame starts on a clock where data_valid=1 and busy=0.
- par_en  input  1  1 = insert parity bit.
- par_typ  input  1  0 = even parity, 1 = odd parity.
- prescale  input  PRESCALE_WIDTH  clocks per bit.
- tx_out  output  1  serial line; idles high.
- busy  output  1  high while a frame is in progress.

Behaviour:
- Reset:
  - Synchronous: effective on a rising clk edge with reset=1, including mid-frame.
  - Values after that edge: tx_out=1, busy=0, state=IDLE, edge_cnt=0, bit_cnt=0.
  - A frame in progress is aborted immediately; no partial stop bit is emitted.
- Registers and counters:
  - tx_out and busy are registers; there is no combinational path from inputs to outputs.
  - edge_cnt counts 0..prescale-1 within a bit. A bit ends on the clock where edge_cnt == prescale-1 (PRESCALE_WIDTH-bit arithmetic), then edge_cnt wraps to 0.
  - prescale=0 therefore gives 2^PRESCALE_WIDTH (64) clocks per bit.
  - bit_cnt counts data bits 0..DATA_WIDTH-1.
- Accept:
  - In IDLE, on an edge with data_valid=1, the block latches p_data, par_en, par_typ and prescale.
  - Changes to these inputs during the frame are ignored.
  - On that same edge: state->START, tx_out<=0, busy<=1, edge_cnt<=0.
  - data_valid while busy=1 is ignored and not queued.
- States:
  - IDLE: tx_out=1, busy=0.
  - START: tx_out=0 for prescale clocks, then DATA with tx_out<=data[0].
  - DATA: tx_out=data[bit_cnt] for prescale clocks per bit, LSB first.
    - After the bit with bit_cnt=DATA_WIDTH-1: go to PARITY if par_en latched 1, else STOP.
  - PARITY: tx_out = (^data) XOR par_typ for prescale clocks, then STOP.
    - Even parity makes the total count of ones including the parity bit even; odd makes it odd.
  - STOP: tx_out=1 for prescale clocks. On the final stop clock edge: state->IDLE, busy<=0, tx_out stays 1.
- Timing:
  - Frame length = prescale x (DATA_WIDTH+2+par_en) clocks, measured from the accept edge to the busy-deassert edge.
  - Back-to-back frames: data_valid is sampled only in IDLE, so the minimum gap between stop and the next start is 1 clock.
  - If data_valid is held high continuously, consecutive frames are sent with that 1-clock idle gap.
- Simultaneous events:
  - reset=1 with data_valid=1: reset wins and no frame starts.
  - reset deasserted with data_valid=1 on the next edge: the frame starts normally.

Test Plan:
- Basic frame, no parity:
  - Stimulus: prescale=8, par_en=0, p_data=8'hA5, data_valid pulse.
  - Required: tx_out = 0,1,0,1,0,0,1,0,1,1, each level held 8 clocks; busy high for exactly 80 clocks, then low.
- Even parity:
  - Stimulus: prescale=16, par_en=1, par_typ=0, p_data=8'h03.
  - Required: parity bit = 0; frame = 176 clocks; stop high.
- Odd parity:
  - Stimulus: par_typ=1, p_data=8'h07.
  - Required: parity bit = 0 (three ones plus parity must be odd).
  - Repeat with p_data=8'h00: parity bit = 1.
- Request and input changes while busy:
  - Stimulus: a second data_valid pulse and a p_data change mid-frame.
  - Required: ignored; serial output still matches the first byte; no second frame starts.
- Reset mid-frame:
  - Stimulus: assert reset during DATA bit 3 for 1 clock.
  - Required: tx_out=1 and busy=0 from the next edge. A new request then produces a full clean frame.
- Back-to-back and prescale wrap:
  - Stimulus: data_valid held high with prescale=8.
  - Required: frames separated by exactly 1 idle-high clock.
  - Stimulus: prescale=0.
  - Required: each bit is 64 clocks.

Source files
------------

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: serialises one parallel word into a UART frame (start, LSB-first data, optional parity, stop)
module uart_tx_frame #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [DATA_WIDTH-1:0]     p_data,
    input  logic                      data_valid,
    input  logic                      par_en,
    input  logic                      par_typ,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic                      tx_out,
    output logic                      busy
);
    localparam int BW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                    state_q, state_d;
    logic [PRESCALE_WIDTH-1:0] edge_q, edge_d, prescale_q, prescale_d;
    logic [BW-1:0]             bit_q, bit_d, bit_nxt;
    logic [DATA_WIDTH-1:0]     data_q, data_d;
    logic                      par_en_q, par_en_d, par_typ_q, par_typ_d;
    logic                      tx_q, tx_d, busy_q, busy_d, bit_end;

    assign tx_out  = tx_q;
    assign busy    = busy_q;
    assign bit_nxt = bit_q + 1'b1;
    // prescale of 0 wraps to the full counter range because the compare is PRESCALE_WIDTH-bit
    assign bit_end = edge_q == prescale_q - 1'b1;

    // next-state: accept in IDLE, then step through the frame one bit per prescale clocks
    always_comb begin
        state_d    = state_q;
        edge_d     = edge_q;
        bit_d      = bit_q;
        data_d     = data_q;
        prescale_d = prescale_q;
        par_en_d   = par_en_q;
        par_typ_d  = par_typ_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        if (state_q == IDLE) begin
            tx_d   = 1'b1;
            busy_d = 1'b0;
            if (data_valid) begin
                data_d     = p_data;
                par_en_d   = par_en;
                par_typ_d  = par_typ;
                prescale_d = prescale;
                state_d    = START;
                tx_d       = 1'b0;
                busy_d     = 1'b1;
                edge_d     = '0;
            end
        end else begin
            edge_d = bit_end ? '0 : edge_q + 1'b1;
            if (bit_end) begin
                case (state_q)
                    START: begin
                        state_d = DATA;
                        bit_d   = '0;
                        tx_d    = data_q[0];
                    end
                    DATA: begin
                        if (bit_q == BW'(DATA_WIDTH - 1)) begin
                            state_d = par_en_q ? PARITY : STOP;
                            tx_d    = par_en_q ? (^data_q) ^ par_typ_q : 1'b1;
                            bit_d   = '0;
                        end else begin
                            bit_d = bit_nxt;
                            tx_d  = data_q[bit_nxt];
                        end
                    end
                    PARITY: begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end
                    default: begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                        busy_d  = 1'b0;
                    end
                endcase
            end
        end
    end

    // state and output registers; reset aborts any frame and returns the line to idle-high
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            edge_q     <= '0;
            bit_q      <= '0;
            data_q     <= '0;
            prescale_q <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            edge_q     <= edge_d;
            bit_q      <= bit_d;
            data_q     <= data_d;
            prescale_q <= prescale_d;
            par_en_q   <= par_en_d;
            par_typ_q  <= par_typ_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: table, hand-written and random frames checked against a bit-list frame model
module tb_uart_tx_frame;
    logic       clk = 1'b0, reset = 1'b1, data_valid = 1'b0, par_en = 1'b0, par_typ = 1'b0;
    logic [7:0] p_data = '0;
    logic [5:0] prescale = 6'd8;
    logic       tx_out, busy;
    int         n_tests = 0, n_fail = 0;

    uart_tx_frame dut (
        .clk(clk), .reset(reset), .p_data(p_data), .data_valid(data_valid),
        .par_en(par_en), .par_typ(par_typ), .prescale(prescale),
        .tx_out(tx_out), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       pt;
        logic [5:0] ps;
        int         len;
        int         par;
    } vec_t;

    task automatic check(input string nm, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    // Sends one frame and compares every clock against the expected line levels.
    // glitch >= 0 pokes a new request and new inputs at that sample; hold keeps data_valid high.
    task automatic do_frame(input logic [7:0] d, input logic pe, input logic pt, input logic [5:0] ps,
                            input int glitch, input bit hold, input string nm,
                            output int blen, output int pbit);
        int   p, nb, errs, first;
        logic bits[$];
        logic etx, ebusy;
        p = (ps == 0) ? 64 : int'(ps);
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (pe) bits.push_back((^d) ^ pt);
        bits.push_back(1'b1);
        nb = bits.size();
        @(negedge clk);
        p_data = d; par_en = pe; par_typ = pt; prescale = ps; data_valid = 1'b1;
        @(negedge clk);
        if (!hold) data_valid = 1'b0;
        errs = 0; first = -1; blen = 0; pbit = -1;
        for (int j = 0; j < nb * p + 1; j++) begin
            if (j > 0) @(negedge clk);
            if (glitch >= 0 && j == glitch + 1) data_valid = 1'b0;
            etx   = j < nb * p ? bits[j / p] : 1'b1;
            ebusy = j < nb * p;
            if (tx_out !== etx || busy !== ebusy) begin
                errs++;
                if (first < 0) first = j;
            end
            if (busy === 1'b1) blen++;
            if (pe && j == (nb - 2) * p + p / 2) pbit = int'(tx_out);
            if (j == glitch) begin
                data_valid = 1'b1; p_data = ~d; par_en = ~pe; par_typ = ~pt; prescale = ps + 6'd3;
            end
        end
        if (!hold) repeat (3) begin
            @(negedge clk);
            if (busy !== 1'b0 || tx_out !== 1'b1) begin
                errs++;
                if (first < 0) first = nb * p + 1;
            end
        end
        check($sformatf("%s waveform bad clocks (first at %0d)", nm, first), errs, 0);
    endtask

    task automatic wait_idle(input string nm, input int req);
        int cnt;
        cnt = 0;
        while (busy !== 1'b0 && cnt < 2000) begin
            @(negedge clk);
            cnt++;
        end
        check(nm, cnt, req);
    endtask

    vec_t vecs[5];
    int   blen, pbit;

    initial begin
        vecs[0] = '{8'hA5, 1'b0, 1'b0, 6'd8,  80,  -1};
        vecs[1] = '{8'h03, 1'b1, 1'b0, 6'd16, 176, 0};
        vecs[2] = '{8'h07, 1'b1, 1'b1, 6'd16, 176, 0};
        vecs[3] = '{8'h00, 1'b1, 1'b1, 6'd16, 176, 1};
        vecs[4] = '{8'h3C, 1'b0, 1'b0, 6'd0,  640, -1};

        repeat (3) @(negedge clk);
        check("reset tx_out", int'(tx_out), 1);
        check("reset busy", int'(busy), 0);
        reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            do_frame(vecs[i].d, vecs[i].pe, vecs[i].pt, vecs[i].ps, -1, 1'b0,
                     $sformatf("vec%0d", i), blen, pbit);
            check($sformatf("vec%0d busy length", i), blen, vecs[i].len);
            if (vecs[i].pe) check($sformatf("vec%0d parity bit", i), pbit, vecs[i].par);
        end

        do_frame(8'h5A, 1'b1, 1'b0, 6'd10, 37, 1'b0, "busy glitch", blen, pbit);
        check("busy glitch length", blen, 110);

        @(negedge clk);
        p_data = 8'hA5; par_en = 1'b0; prescale = 6'd8; data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        repeat (34) @(negedge clk);
        reset = 1'b1; data_valid = 1'b1;
        @(negedge clk);
        check("mid-frame reset tx_out", int'(tx_out), 1);
        check("mid-frame reset busy", int'(busy), 0);
        reset = 1'b0;
        @(negedge clk);
        check("start after reset tx_out", int'(tx_out), 0);
        check("start after reset busy", int'(busy), 1);
        data_valid = 1'b0;
        wait_idle("post-reset frame length", 80);
        do_frame(8'h96, 1'b1, 1'b1, 6'd4, -1, 1'b0, "clean after reset", blen, pbit);

        do_frame(8'hC3, 1'b0, 1'b0, 6'd8, -1, 1'b1, "b2b first", blen, pbit);
        @(negedge clk);
        check("b2b second start tx_out", int'(tx_out), 0);
        check("b2b second start busy", int'(busy), 1);
        data_valid = 1'b0;
        wait_idle("b2b second frame length", 80);

        for (int k = 0; k < 15; k++) begin
            logic [7:0] rd;
            logic       rpe, rpt;
            logic [5:0] rps;
            rd  = 8'($urandom);
            rpe = 1'($urandom_range(0, 1));
            rpt = 1'($urandom_range(0, 1));
            rps = 6'($urandom_range(0, 20));
            do_frame(rd, rpe, rpt, rps, -1, 1'b0, $sformatf("rand%0d", k), blen, pbit);
            check($sformatf("rand%0d busy length", k), blen,
                  (rps == 0 ? 64 : int'(rps)) * (10 + int'(rpe)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
